uart_tx_fifo: RTL and testbench

Transmit-side companion to the board UART receive path: buffers bytes from fabric logic in a small FIFO and serialises them 8N1 on the UART TX pin, LSB first. It lets blocks such as the seconds counter and LED command logic send replies and status to the host without managing TX timing. The block sits between fabric byte producers and the top-level UART_TX pad, clocked from the 25.125 MHz PLL domain.

---
 rtl/uart_tx_fifo_if.sv | 24 ++
 rtl/uart_tx_fifo.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Byte-producer side of the UART transmit FIFO: write strobe in, FIFO status and serial line out.
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic              i_Wr_DV;
  logic [7:0]        i_Wr_Byte;
  logic              o_Full;
  logic              o_Empty;
  logic [ADDR_W:0]   o_Count;
  logic              o_Overflow;
  logic              o_TX_Active;
  logic              o_TX_Serial;
  logic              o_TX_Done;

  modport master (
    output i_Wr_DV, i_Wr_Byte,
    input  o_Full, o_Empty, o_Count, o_Overflow, o_TX_Active, o_TX_Serial, o_TX_Done
  );

  modport slave (
    input  i_Wr_DV, i_Wr_Byte,
    output o_Full, o_Empty, o_Count, o_Overflow, o_TX_Active, o_TX_Serial, o_TX_Done
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeding an LSB-first serialiser
// that chains frames back to back while bytes are queued.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_W       = 4
) (
  input  logic          i_Clock,
  input  logic          i_Reset,
  uart_tx_fifo_if.slave bus
);

  localparam int CW    = ADDR_W + 1;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CLK = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CW-1:0]     count_q;
  logic [CW-1:0]     count_n;
  logic              full_q;
  logic              empty_q;
  logic              overflow_q;
  logic              wr_en;
  logic              pop;

  tx_state_t         state_q, state_n;
  logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_n;
  logic [2:0]        bit_idx_q, bit_idx_n;
  logic [7:0]        shift_q, shift_n;
  logic              serial_q, serial_n;
  logic              active_q, active_n;
  logic              done_q, done_n;

  // Full is registered state, so a write on the same edge as a pop from a full FIFO is lost.
  assign wr_en = bus.i_Wr_DV && !full_q;

  always_comb begin
    count_n = count_q;
    case ({wr_en, pop})
      2'b10:   count_n = count_q + CW'(1);
      2'b01:   count_n = count_q - CW'(1);
      default: count_n = count_q;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (wr_en) begin
      mem[wr_ptr] <= bus.i_Wr_Byte;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      count_q <= count_n;
      full_q  <= (count_n == CW'(FIFO_DEPTH));
      empty_q <= (count_n == '0);
      if (bus.i_Wr_DV && full_q) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Pops happen only from IDLE or at the last stop-bit cycle, which is what removes the idle gap between frames.
  always_comb begin
    state_n   = state_q;
    clk_cnt_n = clk_cnt_q;
    bit_idx_n = bit_idx_q;
    shift_n   = shift_q;
    done_n    = 1'b0;
    pop       = 1'b0;

    case (state_q)
      IDLE: begin
        if (!empty_q) begin
          pop       = 1'b1;
          shift_n   = mem[rd_ptr];
          clk_cnt_n = '0;
          bit_idx_n = '0;
          state_n   = START;
        end
      end
      START: begin
        if (clk_cnt_q == LAST_CLK) begin
          clk_cnt_n = '0;
          bit_idx_n = '0;
          state_n   = DATA;
        end else begin
          clk_cnt_n = clk_cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (clk_cnt_q == LAST_CLK) begin
          clk_cnt_n = '0;
          if (bit_idx_q == 3'd7) begin
            state_n = STOP;
          end else begin
            bit_idx_n = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_n = clk_cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (clk_cnt_q == LAST_CLK) begin
          done_n    = 1'b1;
          clk_cnt_n = '0;
          if (!empty_q) begin
            pop       = 1'b1;
            shift_n   = mem[rd_ptr];
            bit_idx_n = '0;
            state_n   = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          clk_cnt_n = clk_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    case (state_n)
      START:   serial_n = 1'b0;
      DATA:    serial_n = shift_n[bit_idx_n];
      default: serial_n = 1'b1;
    endcase
    active_n = (state_n != IDLE);
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      clk_cnt_q <= clk_cnt_n;
      bit_idx_q <= bit_idx_n;
      shift_q   <= shift_n;
      serial_q  <= serial_n;
      active_q  <= active_n;
      done_q    <= done_n;
    end
  end

  assign bus.o_Full      = full_q;
  assign bus.o_Empty     = empty_q;
  assign bus.o_Count     = count_q;
  assign bus.o_Overflow  = overflow_q;
  assign bus.o_TX_Active = active_q;
  assign bus.o_TX_Serial = serial_q;
  assign bus.o_TX_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 4 clocks per bit: single frame, back-to-back frames,
// overflow and pointer wrap, write-on-pop while full, and reset mid-frame.
module tb_uart_tx_fifo;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checkCount = 0;
  int   errorCount = 0;
  logic [7:0] vec [18];

  uart_tx_fifo_if #(.ADDR_W(4)) bus ();

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(16),
    .ADDR_W(4)
  ) dut (
    .i_Clock(clk),
    .i_Reset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic dv, input logic [7:0] b);
    bus.i_Wr_DV   = dv;
    bus.i_Wr_Byte = b;
    tick();
  endtask

  function automatic logic expBit(input logic [7:0] b, input int n);
    if (n == 0) return 1'b0;
    if (n == 9) return 1'b1;
    return b[n-1];
  endfunction

  // Walks one frame cycle by cycle, starting at cycle startI after the pop edge, and
  // leaves time just after the frame's final stop-bit edge.
  task automatic checkFrame(input string tag, input logic [7:0] b, input int startI, input bit wrAtEnd);
    for (int i = startI; i < 10 * CPB; i++) begin
      checkOutput({tag, " serial"}, 32'(bus.o_TX_Serial), 32'(expBit(b, i / CPB)));
      checkOutput({tag, " active"}, 32'(bus.o_TX_Active), 32'd1);
      if (i > 0) checkOutput({tag, " done"}, 32'(bus.o_TX_Done), 32'd0);
      if (wrAtEnd && i == 10 * CPB - 1) begin
        bus.i_Wr_DV   = 1'b1;
        bus.i_Wr_Byte = 8'hEE;
      end
      tick();
      bus.i_Wr_DV = 1'b0;
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bus.i_Wr_DV   = 1'b0;
    bus.i_Wr_Byte = 8'h00;
    for (int j = 0; j < 18; j++) vec[j] = 8'(j * 37 + 5);

    doReset();
    checkOutput("rst serial", 32'(bus.o_TX_Serial), 32'd1);
    checkOutput("rst active", 32'(bus.o_TX_Active), 32'd0);
    checkOutput("rst done", 32'(bus.o_TX_Done), 32'd0);
    checkOutput("rst empty", 32'(bus.o_Empty), 32'd1);
    checkOutput("rst full", 32'(bus.o_Full), 32'd0);
    checkOutput("rst count", 32'(bus.o_Count), 32'd0);
    checkOutput("rst overflow", 32'(bus.o_Overflow), 32'd0);

    // Single byte 0x31: no pop on the write edge, frame starts one edge later.
    applyStimulus(1'b1, 8'h31);
    bus.i_Wr_DV = 1'b0;
    checkOutput("t1 count", 32'(bus.o_Count), 32'd1);
    checkOutput("t1 serial pre", 32'(bus.o_TX_Serial), 32'd1);
    checkOutput("t1 active pre", 32'(bus.o_TX_Active), 32'd0);
    tick();
    checkFrame("t1 0x31", 8'h31, 0, 1'b0);
    checkOutput("t1 done", 32'(bus.o_TX_Done), 32'd1);
    checkOutput("t1 active end", 32'(bus.o_TX_Active), 32'd0);
    checkOutput("t1 serial end", 32'(bus.o_TX_Serial), 32'd1);
    checkOutput("t1 empty end", 32'(bus.o_Empty), 32'd1);
    tick();
    checkOutput("t1 done clr", 32'(bus.o_TX_Done), 32'd0);

    // Three bytes on consecutive cycles, frames chained with no gap.
    applyStimulus(1'b1, 8'h00);
    checkOutput("t2 count a", 32'(bus.o_Count), 32'd1);
    applyStimulus(1'b1, 8'hFF);
    checkOutput("t2 count b", 32'(bus.o_Count), 32'd1);
    applyStimulus(1'b1, 8'hA5);
    bus.i_Wr_DV = 1'b0;
    checkOutput("t2 count peak", 32'(bus.o_Count), 32'd2);
    checkFrame("t2 0x00", 8'h00, 1, 1'b0);
    checkOutput("t2 done a", 32'(bus.o_TX_Done), 32'd1);
    checkFrame("t2 0xFF", 8'hFF, 0, 1'b0);
    checkOutput("t2 done b", 32'(bus.o_TX_Done), 32'd1);
    checkFrame("t2 0xA5", 8'hA5, 0, 1'b0);
    checkOutput("t2 done c", 32'(bus.o_TX_Done), 32'd1);
    checkOutput("t2 active end", 32'(bus.o_TX_Active), 32'd0);
    checkOutput("t2 empty end", 32'(bus.o_Empty), 32'd1);
    tick();

    // Fill while busy, then an 18th write that must be dropped.
    for (int j = 0; j < 18; j++) begin
      applyStimulus(1'b1, (j == 17) ? 8'hEE : vec[j]);
      if (j == 16) begin
        checkOutput("t3 full", 32'(bus.o_Full), 32'd1);
        checkOutput("t3 count16", 32'(bus.o_Count), 32'd16);
        checkOutput("t3 ovf clear", 32'(bus.o_Overflow), 32'd0);
      end
    end
    bus.i_Wr_DV = 1'b0;
    checkOutput("t3 ovf set", 32'(bus.o_Overflow), 32'd1);
    checkOutput("t3 count kept", 32'(bus.o_Count), 32'd16);
    checkFrame("t3 b0", vec[0], 16, 1'b0);
    for (int j = 1; j <= 16; j++) begin
      checkOutput("t3 done", 32'(bus.o_TX_Done), 32'd1);
      checkFrame($sformatf("t3 b%0d", j), vec[j], 0, 1'b0);
    end
    checkOutput("t3 done last", 32'(bus.o_TX_Done), 32'd1);
    checkOutput("t3 active end", 32'(bus.o_TX_Active), 32'd0);
    checkOutput("t3 empty end", 32'(bus.o_Empty), 32'd1);
    checkOutput("t3 ovf sticky", 32'(bus.o_Overflow), 32'd1);

    // Write on the same edge as the end-of-stop pop from a full FIFO.
    doReset();
    checkOutput("t4 ovf reset", 32'(bus.o_Overflow), 32'd0);
    for (int j = 0; j < 17; j++) applyStimulus(1'b1, ~vec[j]);
    bus.i_Wr_DV = 1'b0;
    checkOutput("t4 full", 32'(bus.o_Full), 32'd1);
    checkOutput("t4 count16", 32'(bus.o_Count), 32'd16);
    checkOutput("t4 ovf clear", 32'(bus.o_Overflow), 32'd0);
    checkFrame("t4 b0", ~vec[0], 15, 1'b1);
    checkOutput("t4 ovf set", 32'(bus.o_Overflow), 32'd1);
    checkOutput("t4 count15", 32'(bus.o_Count), 32'd15);
    checkOutput("t4 full clr", 32'(bus.o_Full), 32'd0);
    checkOutput("t4 done", 32'(bus.o_TX_Done), 32'd1);
    for (int j = 1; j <= 16; j++) begin
      checkFrame($sformatf("t4 b%0d", j), ~vec[j], 0, 1'b0);
      checkOutput("t4 done n", 32'(bus.o_TX_Done), 32'd1);
    end
    checkOutput("t4 active end", 32'(bus.o_TX_Active), 32'd0);
    checkOutput("t4 empty end", 32'(bus.o_Empty), 32'd1);
    tick();

    // Reset during data bit 3 of 0x55 with two bytes queued.
    applyStimulus(1'b1, 8'h55);
    applyStimulus(1'b1, 8'h11);
    applyStimulus(1'b1, 8'h22);
    bus.i_Wr_DV = 1'b0;
    checkOutput("t5 count", 32'(bus.o_Count), 32'd2);
    for (int i = 0; i < 16; i++) tick();
    checkOutput("t5 bit3", 32'(bus.o_TX_Serial), 32'd0);
    checkOutput("t5 active mid", 32'(bus.o_TX_Active), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t5 serial", 32'(bus.o_TX_Serial), 32'd1);
    checkOutput("t5 active", 32'(bus.o_TX_Active), 32'd0);
    checkOutput("t5 count0", 32'(bus.o_Count), 32'd0);
    checkOutput("t5 empty", 32'(bus.o_Empty), 32'd1);
    for (int i = 0; i < 60; i++) begin
      checkOutput("t5 quiet serial", 32'(bus.o_TX_Serial), 32'd1);
      checkOutput("t5 quiet active", 32'(bus.o_TX_Active), 32'd0);
      checkOutput("t5 quiet done", 32'(bus.o_TX_Done), 32'd0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
